// File: rtl/re_name_gen_if.sv
// Issue/rename/commit signal bundle for the register re-naming unit.
// The slave modport is the re-namer; the master is the scoreboard/downstream side.
interface re_name_gen_if #(
  parameter int NR_ARCH_REGS    = 32,
  parameter int GEN_BITS        = 2,
  parameter int NR_COMMIT_PORTS = 2
);
  localparam int ARCH_BITS = $clog2(NR_ARCH_REGS);
  localparam int PHYS_BITS = GEN_BITS + ARCH_BITS;

  logic                                        flush_i;
  logic                                        issue_instr_valid_i;
  logic [ARCH_BITS-1:0]                        rs1_i;
  logic [ARCH_BITS-1:0]                        rs2_i;
  logic [ARCH_BITS-1:0]                        rd_i;
  logic                                        issue_ack_o;
  logic                                        issue_instr_valid_o;
  logic [PHYS_BITS-1:0]                        rs1_o;
  logic [PHYS_BITS-1:0]                        rs2_o;
  logic [PHYS_BITS-1:0]                        rd_o;
  logic                                        issue_ack_i;
  logic [NR_COMMIT_PORTS-1:0]                  commit_valid_i;
  logic [NR_COMMIT_PORTS-1:0][ARCH_BITS-1:0]   commit_rd_i;
  logic                                        stall_o;

  modport slave (
    input  flush_i, issue_instr_valid_i, rs1_i, rs2_i, rd_i, issue_ack_i,
           commit_valid_i, commit_rd_i,
    output issue_ack_o, issue_instr_valid_o, rs1_o, rs2_o, rd_o, stall_o
  );

  modport master (
    output flush_i, issue_instr_valid_i, rs1_i, rs2_i, rd_i, issue_ack_i,
           commit_valid_i, commit_rd_i,
    input  issue_ack_o, issue_instr_valid_o, rs1_o, rs2_o, rd_o, stall_o
  );
endinterface

// File: rtl/re_name_gen.sv
// Generation-based register re-namer: tags operands with per-register generations,
// tracks in-flight writes, stalls on generation exhaustion and restores committed state on flush.
module re_name_gen #(
  parameter int NR_ARCH_REGS    = 32,
  parameter int GEN_BITS        = 2,
  parameter int NR_COMMIT_PORTS = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  re_name_gen_if.slave  bus
);
  localparam int ARCH_BITS = $clog2(NR_ARCH_REGS);
  localparam logic [GEN_BITS-1:0] GEN_ONE = GEN_BITS'(1);
  localparam logic [GEN_BITS-1:0] GEN_MAX = '1;

  logic [GEN_BITS-1:0] spec_gen_q [NR_ARCH_REGS];
  logic [GEN_BITS-1:0] com_gen_q  [NR_ARCH_REGS];
  logic [GEN_BITS-1:0] inflight_q [NR_ARCH_REGS];
  logic [GEN_BITS-1:0] spec_gen_n [NR_ARCH_REGS];
  logic [GEN_BITS-1:0] com_gen_n  [NR_ARCH_REGS];
  logic [GEN_BITS-1:0] inflight_n [NR_ARCH_REGS];

  logic                 rd_nonzero;
  logic                 stall;
  logic                 issue_valid;
  logic                 issue_ack;
  logic                 commit_underflow;
  logic [GEN_BITS-1:0]  rd_next_gen;

  // Stall looks only at registered inflight, so a same-cycle commit cannot lift it.
  assign rd_nonzero  = (bus.rd_i != '0);
  assign stall       = bus.issue_instr_valid_i && rd_nonzero && (inflight_q[bus.rd_i] == GEN_MAX);
  assign issue_valid = bus.issue_instr_valid_i && !stall && !bus.flush_i;
  assign issue_ack   = bus.issue_ack_i && issue_valid;
  assign rd_next_gen = spec_gen_q[bus.rd_i] + GEN_ONE;

  assign bus.stall_o             = stall;
  assign bus.issue_instr_valid_o = issue_valid;
  assign bus.issue_ack_o         = issue_ack;
  assign bus.rs1_o               = {spec_gen_q[bus.rs1_i], bus.rs1_i};
  assign bus.rs2_o               = {spec_gen_q[bus.rs2_i], bus.rs2_i};
  assign bus.rd_o                = rd_nonzero ? {rd_next_gen, bus.rd_i} : '0;

  // Issue is applied before commits so an issue and commit to the same register net out.
  always_comb begin
    spec_gen_n       = spec_gen_q;
    com_gen_n        = com_gen_q;
    inflight_n       = inflight_q;
    commit_underflow = 1'b0;

    if (issue_ack && rd_nonzero) begin
      spec_gen_n[bus.rd_i] = rd_next_gen;
      inflight_n[bus.rd_i] = inflight_q[bus.rd_i] + GEN_ONE;
    end

    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (bus.commit_valid_i[p] && (bus.commit_rd_i[p] != '0)) begin
        com_gen_n[bus.commit_rd_i[p]] = com_gen_n[bus.commit_rd_i[p]] + GEN_ONE;
        if (inflight_n[bus.commit_rd_i[p]] == '0) begin
          commit_underflow = 1'b1;
        end else begin
          inflight_n[bus.commit_rd_i[p]] = inflight_n[bus.commit_rd_i[p]] - GEN_ONE;
        end
      end
    end

    if (bus.flush_i) begin
      spec_gen_n = com_gen_n;
      for (int r = 0; r < NR_ARCH_REGS; r++) begin
        inflight_n[r] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR_ARCH_REGS; r++) begin
        spec_gen_q[r] <= '0;
        com_gen_q[r]  <= '0;
        inflight_q[r] <= '0;
      end
    end else begin
      spec_gen_q <= spec_gen_n;
      com_gen_q  <= com_gen_n;
      inflight_q <= inflight_n;
    end
  end

`ifndef SYNTHESIS
  // A commit with nothing in flight means the scoreboard and re-namer disagree.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!commit_underflow)
        else $error("re_name_gen: commit to a register with no in-flight write");
    end
  end
`endif
endmodule

// File: doc/re_name_gen.md
# re_name_gen

Parametrised register re-naming unit between the scoreboard issue port and issue/read-operands. Each architectural register has a GEN_BITS-wide generation. Source operands are tagged with the current generation of their register. Destinations get the next generation. The unit tracks in-flight writes per register, stalls issue when a register runs out of generations, and restores the committed mapping on flush. It replaces the 1-bit toggle re-namer and adds commit tracking, a stall on generation exhaustion, and flush recovery.

## Interface
Parameters:
- NR_ARCH_REGS, 32: number of architectural registers; power of two; ARCH_BITS = $clog2(NR_ARCH_REGS).
- GEN_BITS, 2: generation bits per register; PHYS_BITS = GEN_BITS + ARCH_BITS.
- NR_COMMIT_PORTS, 2: number of commit ports.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discards all uncommitted speculative state.
- issue_instr_valid_i  in  1  scoreboard has an instruction to issue.
- rs1_i, rs2_i, rd_i  in  ARCH_BITS each  architectural source and destination registers.
- issue_ack_o  out  1  acknowledge to the scoreboard.
- issue_instr_valid_o  out  1  renamed instruction is valid.
- rs1_o, rs2_o, rd_o  out  PHYS_BITS each  renamed registers, formatted {generation, arch}.
- issue_ack_i  in  1  downstream acceptance.
- commit_valid_i  in  NR_COMMIT_PORTS  per-port commit of a register write.
- commit_rd_i  in  NR_COMMIT_PORTS x ARCH_BITS  committed destination register.
- stall_o  out  1  issue is blocked by generation exhaustion.

## Operation
- State per register r:
  - spec_gen_q[r] (GEN_BITS): newest speculative generation.
  - com_gen_q[r] (GEN_BITS): committed generation.
  - inflight_q[r] (GEN_BITS): issued writes not yet committed.
- Reset clears every table to 0.
- Register 0 is never renamed:
  - Its generation is always 0.
  - Its inflight count stays 0.
  - It never causes a stall.
  - Acks and commits to register 0 are ignored.
- Rename is combinational:
  - rs1_o = {spec_gen_q[rs1_i], rs1_i}.
  - rs2_o = {spec_gen_q[rs2_i], rs2_i}.
  - rd_o = {spec_gen_q[rd_i]+1 mod 2^GEN_BITS, rd_i}, or {0,0} when rd_i = 0.
- stall_o = issue_instr_valid_i && rd_i != 0 && inflight_q[rd_i] == 2^GEN_BITS-1.
- Handshake:
  - issue_instr_valid_o = issue_instr_valid_i && !stall_o && !flush_i.
  - issue_ack_o = issue_ack_i && issue_instr_valid_o.
  - Downstream asserts issue_ack_i only while issue_instr_valid_o is high.
- On an accepted issue (issue_ack_o with rd_i != 0):
  - spec_gen[rd_i] increments modulo 2^GEN_BITS.
  - inflight[rd_i] increments.
- On commit (commit_valid_i[p] with commit_rd_i[p] != 0):
  - com_gen[commit_rd_i[p]] increments.
  - inflight[commit_rd_i[p]] decrements.
  - Ports hitting the same register in one cycle add up: two ports on register 7 give +2 and -2.
- Issue and commit to the same register in one cycle: both updates apply, so inflight nets to zero and spec_gen still increments.
- Flush: flush_i wins over issue.
  - spec_gen_n = com_gen_n, where com_gen_n includes any commits in the same cycle.
  - All inflight counts clear to 0.
  - No ack is produced.
- Commit to a register with inflight 0 is illegal:
  - inflight saturates at 0.
  - A simulation assertion fires.
- Stall is evaluated on registered inflight only. A same-cycle commit does not lift a stall until the next cycle.

## Timing
- Rename path has zero latency, input to output combinational.
- Table updates take effect on the next clk_i rising edge.
- A back-to-back issue to the same rd in the next cycle sees the incremented generation.
- Output values after reset:
  - issue_instr_valid_o, issue_ack_o and stall_o are 0 when inputs are idle.
  - Renamed outputs carry generation 0.
- A reset assertion mid-operation clears all tables asynchronously. Outputs become pure functions of the inputs with generation 0.
- Flush takes one cycle. Issue is allowed again in the cycle after flush_i deasserts.

## Test plan
Defaults are used unless stated.
- Issue rd=5 three times with ack, no commits:
  - rd_o carries generations 1, 2, 3.
  - On the fourth request, stall_o=1 and issue_ack_o=0.
  - Commit rd=5 once; the next cycle the issue is acked with rd_o generation 0 (wrap).
- Issue rd=3 (gets gen 1), then rs1_i=3, rs2_i=4 -> rs1_o={1,3}, rs2_o={0,4}.
  - This checks that rs2 uses its own register's generation.
- Issue rd=8 twice, commit rd=8 once, then pulse flush_i:
  - Next cycle rs1_i=8 gives generation 1 and inflight[8]=0.
- Issue rd=0 ten times:
  - No stall, rd_o={0,0}, rs1_i=0 gives generation 0.
- Same cycle: ack rd=9 plus commit rd=9 on both ports, after two prior issues:
  - inflight[9] = 2+1-2 = 1, spec_gen[9]=3, com_gen[9]=2.
- Drop rst_ni low mid-sequence with inflight counts nonzero:
  - All generations read 0 and stall_o=0 immediately.
